// File: rtl/conv_result_reader_pkg.sv
// rtl/conv_result_reader_pkg.sv - shared state encoding and sizing constants for the conv result path
package conv_result_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STREAM,
    ST_FINISH
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int MAX_OUT    = 1024;

endpackage

// File: rtl/conv_skid_fifo.sv
// rtl/conv_skid_fifo.sv - two-entry valid/ready FIFO between the memory read port and the result stream
module conv_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] s_tdata_i,
  input  logic         s_tvalid_i,
  output logic [W-1:0] m_tdata_o,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign pop  = m_tvalid_o && m_tready_i;
  // A full FIFO may still accept a word in the same cycle its head leaves.
  assign push = s_tvalid_i && (!full_o || pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_tdata_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_tdata_o  = mem_q[rd_ptr_q];
  assign m_tvalid_o = (count_q != 2'd0);
  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);

endmodule

// File: rtl/conv_result_reader.sv
// rtl/conv_result_reader.sv - streams N=(I-K+1)^2 result words from output memory once the conv unit reports done
module conv_result_reader #(
  parameter int DATA_W = conv_result_reader_pkg::DATA_W_DEF,
  parameter int ADDR_W = conv_result_reader_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        I,
  input  logic [2:0]        K,
  input  logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              stream_done,
  output logic              err
);

  import conv_result_reader_pkg::*;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q;
  logic            done_q;
  logic [9:0]      i_q;
  logic [2:0]      k_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] n_q;
  logic            pending_q;
  logic            pending_last_q;
  logic            busy_q;
  logic            stream_done_q;
  logic            err_q;

  logic [19:0]     m_calc;
  logic [19:0]     n_calc;
  logic            geom_bad;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DATA_W:0] fifo_head;
  logic            pop;
  logic            issue;
  logic [1:0]      occ_raw;
  logic [1:0]      occ;

  assign m_calc   = 20'(i_q) - 20'(k_q) + 20'd1;
  assign n_calc   = m_calc * m_calc;
  assign geom_bad = (k_q == 3'd0) || ({7'd0, k_q} > i_q) || (n_calc > 20'(MAX_OUT));

  assign pop     = out_valid && out_ready;
  assign occ_raw = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign occ     = occ_raw - {1'b0, pop};
  // Counting the slot freed this cycle lets a new read go out every cycle while the sink keeps up.
  assign issue   = (state_q == ST_STREAM) && (cnt_q < n_q) &&
                   ((occ + {1'b0, pending_q}) < 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      i_q            <= '0;
      k_q            <= '0;
      cnt_q          <= '0;
      n_q            <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      busy_q         <= 1'b0;
      stream_done_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      done_q         <= done;
      pending_q      <= issue;
      pending_last_q <= issue && (cnt_q == n_q - ONE);
      stream_done_q  <= 1'b0;
      if (issue) begin
        cnt_q <= cnt_q + ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (done && !done_q) begin
            i_q     <= I;
            k_q     <= K;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (geom_bad) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            err_q   <= 1'b0;
            n_q     <= n_calc[ADDR_W:0];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (pop && out_last) begin
            busy_q        <= 1'b0;
            stream_done_q <= 1'b1;
            state_q       <= ST_FINISH;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  conv_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .s_tdata_i  ({pending_last_q, rd_data}),
    .s_tvalid_i (pending_q),
    .m_tdata_o  (fifo_head),
    .m_tvalid_o (out_valid),
    .m_tready_i (out_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rd_en       = issue;
  assign rd_addr     = cnt_q[ADDR_W-1:0];
  assign out_data    = fifo_head[DATA_W-1:0];
  assign out_last    = out_valid && fifo_head[DATA_W];
  assign busy        = busy_q;
  assign stream_done = stream_done_q;
  assign err         = err_q;

endmodule
